// File: rtl/fsm_pkg.sv
// fsm_pkg: shared state encoding and width limits for the serial datapath blocks
package fsm_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int SUB_WIDTH_MAX = 32;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit difference/borrow cell
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, LSB first, valid/ready in and out
// SERIAL_SUB_UNDERFLOW_CLAMP_EN forces diff to 0 when the result borrows
module serial_subtractor
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
    logic [CW-1:0]    cnt;
    logic             bw, d, bo;
    full_subtractor u_cell (.a(a_sh[0]), .b(b_sh[0]), .bin(bw), .d(d), .bout(bo));
    assign res_nxt   = {d, res[WIDTH-1:1]};
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            bw     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    res   <= '0;
                    cnt   <= '0;
                    bw    <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_nxt;
                    bw   <= bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        borrow <= bo;
`ifdef SERIAL_SUB_UNDERFLOW_CLAMP_EN
                        diff   <= bo ? '0 : res_nxt;
`else
                        diff   <= res_nxt;
`endif
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench with directed corner cases and random operands
module tb_serial_subtractor;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, borrow, busy;
    logic [W-1:0] diff;
    int           checks = 0;
    int           errors = 0;
    int           sb_d[$];
    int           sb_b[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_bw(int x, int y);
        return (x < y) ? 1 : 0;
    endfunction

    function automatic int exp_diff(int x, int y);
`ifdef SERIAL_SUB_UNDERFLOW_CLAMP_EN
        if (x < y) return 0;
`endif
        return (x - y + 256) % 256;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_d.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                chk("diff", int'(diff), sb_d.pop_front());
                chk("borrow", int'(borrow), sb_b.pop_front());
            end
        end
    end

    task automatic send(input int x, input int y);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        in_valid = 1'b1;
        a = W'(x);
        b = W'(y);
        @(posedge clk);
        sb_d.push_back(exp_diff(x, y));
        sb_b.push_back(exp_bw(x, y));
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (busy && n < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
        if (busy) chk("done_timeout", 1, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_borrow", int'(borrow), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        send(200, 75);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 8);
        wait_done(0);
        send(75, 200);  wait_done(0);
        send(255, 255); wait_done(0);
        send(0, 0);     wait_done(0);
        send(0, 1);     wait_done(0);

        out_ready = 1'b0;
        send(123, 45);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_diff", int'(diff), exp_diff(123, 45));
            chk("stall_borrow", int'(borrow), exp_bw(123, 45));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);

        send(100, 37);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 8'd9;
        b = 8'd3;
        chk("run_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(0);
        repeat (2) @(posedge clk);
        #1;
        chk("no_queued_op", int'(busy), 0);

        send(50, 20);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_d.delete();
        sb_b.delete();
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_borrow", int'(borrow), 0);
        send(180, 33);
        wait_done(0);

        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            wait_done(1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
